// File: rtl/fully_pipelined_subtractor_pkg.sv
// Shared constants and full-subtractor reference expressions for the pipelined subtractor
// and its benches.
package fully_pipelined_subtractor_pkg;

  localparam int FPS_DEFAULT_WIDTH = 32'sd4;

  // Enabled edges from operand capture to result visibility: one per borrow stage plus the output register.
  function automatic int fps_latency(input int width);
    return width + 32'sd1;
  endfunction

  // Start bit of stage 'stage' inside the packed triangle of shrinking subtrahend registers.
  function automatic int fps_b_offset(input int width, input int stage);
    return stage * width - (stage * (stage - 32'sd1)) / 32'sd2;
  endfunction

  function automatic logic fs_diff(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

endpackage

// File: rtl/fully_pipelined_subtractor_dff.sv
// Register primitive with advance enable and synchronous active-low clear.
module fully_pipelined_subtractor_dff #(
  parameter int W = 32'sd1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over enable; otherwise load only when the pipeline advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fully_pipelined_subtractor_fullsub.sv
// One-bit combinational full subtractor: d = a - b - bi, bo = borrow out.
module fullsubtractor
  import fully_pipelined_subtractor_pkg::*;
(
  output logic bo,
  output logic d,
  input  logic a,
  input  logic b,
  input  logic bi
);

  // Single-bit difference and borrow from the shared expressions.
  always_comb begin
    d  = fs_diff(a, b, bi);
    bo = fs_borrow(a, b, bi);
  end

endmodule

// File: rtl/fully_pipelined_subtractor.sv
// Bit-serial-in-time ripple-borrow subtractor: stage i resolves bit i, so each
// pipeline step has one full subtractor of logic.
module fully_pipelined_subtractor
  import fully_pipelined_subtractor_pkg::*;
#(
  parameter int WIDTH = FPS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             out_valid
);

  localparam int BTOT     = fps_b_offset(WIDTH, WIDTH);
  localparam int BMSB_IDX = fps_b_offset(WIDTH, WIDTH - 32'sd1) - 32'sd1;

  logic [WIDTH-1:0] word_q [WIDTH];
  logic [BTOT-1:0]  brem_q;
  logic [WIDTH-1:0] br_q;
  logic [WIDTH-1:0] vld_q;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] bo_s;

  logic [1:0]       msb_d;
  logic [1:0]       msb_q;
  logic [WIDTH+2:0] out_d;
  logic [WIDTH+2:0] out_q;

  for (genvar i = 32'sd0; i < WIDTH; i++) begin : g_stage
    localparam int BW   = WIDTH - i;
    localparam int BOFF = fps_b_offset(WIDTH, i);

    logic [WIDTH-1:0] word_d;
    logic [BW-1:0]    brem_d;
    logic             br_d;
    logic             vld_d;

    if (i == 32'sd0) begin : g_head
      // First stage captures operands directly from the ports.
      always_comb begin
        word_d = a;
        brem_d = b;
        br_d   = bin;
        vld_d  = in_valid;
      end
    end else begin : g_body
      localparam int PBOFF = fps_b_offset(WIDTH, i - 32'sd1);

      // Previous bit replaced by its difference; its b bit is dropped.
      always_comb begin
        word_d           = word_q[i-32'sd1];
        word_d[i-32'sd1] = diff_s[i-32'sd1];
        brem_d           = brem_q[PBOFF+32'sd1 +: BW];
        br_d             = bo_s[i-32'sd1];
        vld_d            = vld_q[i-32'sd1];
      end
    end

    fully_pipelined_subtractor_dff #(.W(WIDTH)) u_word (
      .clk(clk), .rst_n(rst_n), .en(en), .d(word_d), .q(word_q[i])
    );
    fully_pipelined_subtractor_dff #(.W(BW)) u_brem (
      .clk(clk), .rst_n(rst_n), .en(en), .d(brem_d), .q(brem_q[BOFF +: BW])
    );
    fully_pipelined_subtractor_dff #(.W(32'sd1)) u_br (
      .clk(clk), .rst_n(rst_n), .en(en), .d(br_d), .q(br_q[i])
    );
    fully_pipelined_subtractor_dff #(.W(32'sd1)) u_vld (
      .clk(clk), .rst_n(rst_n), .en(en), .d(vld_d), .q(vld_q[i])
    );

    fullsubtractor u_fs (
      .bo (bo_s[i]),
      .d  (diff_s[i]),
      .a  (word_q[i][i]),
      .b  (brem_q[BOFF]),
      .bi (br_q[i])
    );
  end

  // Operand sign bits kept alongside the last stage; the MSB of the word gets overwritten there.
  always_comb begin
    msb_d = {word_q[WIDTH-32'sd2][WIDTH-32'sd1], brem_q[BMSB_IDX]};
  end

  fully_pipelined_subtractor_dff #(.W(32'sd2)) u_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .d(msb_d), .q(msb_q)
  );

  // Final word, borrow, signed overflow and valid packed for the output register.
  always_comb begin
    out_d                    = '0;
    out_d[WIDTH-1:0]         = word_q[WIDTH-32'sd1];
    out_d[WIDTH-32'sd1]      = diff_s[WIDTH-32'sd1];
    out_d[WIDTH]             = bo_s[WIDTH-32'sd1];
    out_d[WIDTH+32'sd1]      = (msb_q[1] ^ msb_q[0]) & (diff_s[WIDTH-32'sd1] ^ msb_q[1]);
    out_d[WIDTH+32'sd2]      = vld_q[WIDTH-32'sd1];
  end

  fully_pipelined_subtractor_dff #(.W(WIDTH + 32'sd3)) u_out (
    .clk(clk), .rst_n(rst_n), .en(en), .d(out_d), .q(out_q)
  );

  assign d         = out_q[WIDTH-1:0];
  assign bout      = out_q[WIDTH];
  assign ovf       = out_q[WIDTH+32'sd1];
  assign out_valid = out_q[WIDTH+32'sd2];

endmodule

// File: tb/tb_fully_pipelined_subtractor.sv
// Scoreboard bench for fully_pipelined_subtractor (WIDTH=4): stimulus pushes expected
// results, a negedge monitor pops and checks value and arrival edge.
module tb_fully_pipelined_subtractor;
  import fully_pipelined_subtractor_pkg::*;

  localparam int W = 4;
  localparam int L = fps_latency(W);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;
  logic         out_valid;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    int           edge_no;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;

  logic [2*W:0] stream_tab [16];

  always #5 clk = ~clk;

  fully_pipelined_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .bin(bin),
    .d(d), .bout(bout), .ovf(ovf), .out_valid(out_valid)
  );

  // Enabled-edge counter used to check arrival latency.
  always @(posedge clk) if (en) ecnt <= ecnt + 1;

  // Monitor: a result shown while en=1 is consumed at the next edge.
  always @(negedge clk) begin
    if (rst_n && en && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got d=%h bout=%b ovf=%b at edge %0d, expected no valid output",
                 d, bout, ovf, ecnt);
      end else begin
        mon_e = exp_q.pop_front();
        if (d !== mon_e.d || bout !== mon_e.bout || ovf !== mon_e.ovf || ecnt != mon_e.edge_no + L - 1) begin
          errors++;
          $display("FAIL %s: got d=%h bout=%b ovf=%b edge=%0d, expected d=%h bout=%b ovf=%b edge=%0d",
                   mon_e.tag, d, bout, ovf, ecnt, mon_e.d, mon_e.bout, mon_e.ovf, mon_e.edge_no + L - 1);
        end
      end
    end else if (rst_n && en && exp_q.size() > 0 && ecnt >= exp_q[0].edge_no + L - 1) begin
      checks++;
      errors++;
      mon_e = exp_q.pop_front();
      $display("FAIL %s_missing: got out_valid=%b at edge %0d, expected d=%h valid",
               mon_e.tag, out_valid, ecnt, mon_e.d);
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_d"}, d, 4'h0);
    chk({name, "_bout"}, {3'b000, bout}, 4'h0);
    chk({name, "_ovf"}, {3'b000, ovf}, 4'h0);
    chk({name, "_out_valid"}, {3'b000, out_valid}, 4'h0);
  endtask

  // Present one input slot for the next edge and advance past it.
  task automatic step(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi,
                      input logic [W-1:0] ed, input logic eb, input logic eo, input string tag);
    in_valid = v;
    a        = aa;
    b        = bb;
    bin      = bi;
    if (v && en && rst_n) exp_q.push_back('{ed, eb, eo, ecnt + 1, tag});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'hA, 4'h5, 1'b1, 4'h0, 1'b0, 1'b0, "bubble");
  endtask

  function automatic void ref_sub(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi,
                                  output logic [W-1:0] rd, output logic rb, output logic ro);
    int ua, ub, sa, sbv, diff, sdiff;
    ua    = int'(aa);
    ub    = int'(bb);
    sa    = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sbv   = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    diff  = ua - ub - int'(bi);
    sdiff = sa - sbv - int'(bi);
    rd    = diff[W-1:0];
    rb    = (diff < 0);
    ro    = (sdiff < -(2**(W-1))) || (sdiff > 2**(W-1) - 1);
  endfunction

  initial begin
    logic [W-1:0] rd;
    logic         rb;
    logic         ro;

    stream_tab = '{{1'b0, 4'hA, 4'h3}, {1'b1, 4'h3, 4'hA}, {1'b0, 4'hF, 4'hF}, {1'b1, 4'h0, 4'hF},
                   {1'b0, 4'h7, 4'h8}, {1'b1, 4'h8, 4'h7}, {1'b1, 4'h6, 4'h6}, {1'b0, 4'h1, 4'h0},
                   {1'b0, 4'hC, 4'h5}, {1'b1, 4'h4, 4'hB}, {1'b0, 4'h9, 4'h9}, {1'b1, 4'hE, 4'h2},
                   {1'b0, 4'h2, 4'hE}, {1'b1, 4'hB, 4'h4}, {1'b0, 4'h5, 4'hC}, {1'b1, 4'hD, 4'h1}};

    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; a = 4'h0; b = 4'h0; bin = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset("reset_en0");

    rst_n = 1'b1; en = 1'b1;
    step(1'b1, 4'h5, 4'h3, 1'b0, 4'h2, 1'b0, 1'b0, "a5_b3");
    idle(L + 2);

    step(1'b1, 4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0, "a3_b5_wrap");
    step(1'b1, 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, "a0_b0_bin1");
    step(1'b1, 4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, "neg8_minus1_ovf");
    step(1'b1, 4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1, "7_minus_neg1_ovf");
    idle(L + 2);

    for (int i = 0; i < 16; i++) begin
      if (i == 5 || i == 11) idle(1);
      ref_sub(stream_tab[i][2*W-1:W], stream_tab[i][W-1:0], stream_tab[i][2*W], rd, rb, ro);
      step(1'b1, stream_tab[i][2*W-1:W], stream_tab[i][W-1:0], stream_tab[i][2*W], rd, rb, ro,
           $sformatf("stream%0d", i));
    end
    idle(L + 2);

    step(1'b1, 4'h9, 4'h4, 1'b0, 4'h5, 1'b0, 1'b1, "stall0");
    step(1'b1, 4'h2, 4'h2, 1'b1, 4'hF, 1'b1, 1'b0, "stall1");
    step(1'b1, 4'hC, 4'h3, 1'b0, 4'h9, 1'b0, 1'b0, "stall2");
    idle(2);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = 4'hF; b = 4'h1; bin = 1'b0;
      @(posedge clk); #1;
      chk("stall_hold_d", d, 4'h5);
      chk("stall_hold_valid", {3'b000, out_valid}, 4'h1);
      chk("stall_hold_ovf", {3'b000, ovf}, 4'h1);
    end
    en = 1'b1;
    idle(L + 2);

    step(1'b1, 4'h1, 4'h2, 1'b0, 4'hF, 1'b1, 1'b0, "flushed0");
    step(1'b1, 4'h4, 4'h1, 1'b0, 4'h3, 1'b0, 1'b0, "flushed1");
    step(1'b1, 4'h8, 4'h8, 1'b1, 4'hF, 1'b1, 1'b0, "flushed2");
    step(1'b1, 4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0, "flushed3");
    rst_n = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check_reset("reset_midstream");
    rst_n = 1'b1;
    idle(L + 2);
    step(1'b1, 4'h6, 4'h9, 1'b1, 4'hC, 1'b1, 1'b1, "fresh_after_reset");
    idle(L + 2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
